register_file_2w3r: RTL and testbench

//   Parametrised successor to the 8x8 single-write/dual-read register file.

---
 rtl/register_file_2w3r.sv | 118 +++++++++++
 tb/tb_register_file_2w3r.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_2w3r.sv
// Operand store: DEPTH x WIDTH registers, two write ports (B wins collisions),
// three combinational read ports with optional write-through bypass and a sequential bulk clear.
module register_file_2w3r #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              WENA,
    input  logic [ADDR_W-1:0] RWA,
    input  logic [WIDTH-1:0]  busWA,
    input  logic              WENB,
    input  logic [ADDR_W-1:0] RWB,
    input  logic [WIDTH-1:0]  busWB,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    input  logic [ADDR_W-1:0] RZ,
    output logic [WIDTH-1:0]  busX,
    output logic [WIDTH-1:0]  busY,
    output logic [WIDTH-1:0]  busZ,
    input  logic              clr,
    output logic              ready,
    output logic              conflict
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BYP   = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              conflict_q;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];

    logic              wr_ok;
    logic              collide;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] raddr [3];
    logic [WIDTH-1:0]  rdata [3];

    // clr on its sampling edge blocks both writes and suppresses the conflict flag
    assign wr_ok   = (state_q == ST_IDLE) && !clr;
    assign collide = wr_ok && WENA && WENB && (RWA == RWB);
    assign we_a    = wr_ok && WENA && !(ZR && RWA == '0) && !collide;
    assign we_b    = wr_ok && WENB && !(ZR && RWB == '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
        if (state_q == ST_CLEAR) begin
            regs_d[idx_q] = '0;
        end else begin
            if (we_a) regs_d[RWA] = busWA;
            if (we_b) regs_d[RWB] = busWB;
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= collide;
            case (state_q)
                ST_IDLE: begin
                    idx_q <= '0;
                    if (clr) state_q <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign raddr[0] = RX;
    assign raddr[1] = RY;
    assign raddr[2] = RZ;

    // B is checked last so it overrides A; the r0 check is last so r0 never bypasses
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p] = regs_q[raddr[p]];
            if (BYP && wr_ok && WENA && (RWA == raddr[p])) rdata[p] = busWA;
            if (BYP && wr_ok && WENB && (RWB == raddr[p])) rdata[p] = busWB;
            if (ZR && (raddr[p] == '0)) rdata[p] = '0;
        end
    end

    assign busX     = rdata[0];
    assign busY     = rdata[1];
    assign busZ     = rdata[2];
    assign ready    = (state_q == ST_IDLE);
    assign conflict = conflict_q;
endmodule

// File: tb/tb_register_file_2w3r.sv
// Directed bench for register_file_2w3r: vector table for reset/write/bypass/collision,
// hand sequences for bulk clear and reset during clear.
module tb_register_file_2w3r;
    logic       Clk = 1'b0;
    logic       rst_n;
    logic       WENA, WENB, clr;
    logic [2:0] RWA, RWB, RX, RY, RZ;
    logic [7:0] busWA, busWB;
    logic [7:0] busX, busY, busZ;
    logic       ready, conflict;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_2w3r #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut (
        .Clk(Clk), .rst_n(rst_n),
        .WENA(WENA), .RWA(RWA), .busWA(busWA),
        .WENB(WENB), .RWB(RWB), .busWB(busWB),
        .RX(RX), .RY(RY), .RZ(RZ),
        .busX(busX), .busY(busY), .busZ(busZ),
        .clr(clr), .ready(ready), .conflict(conflict)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       wena;
        logic [2:0] rwa;
        logic [7:0] bwa;
        logic       wenb;
        logic [2:0] rwb;
        logic [7:0] bwb;
        logic [2:0] rx, ry, rz;
        logic [7:0] ex, ey, ez;
        logic       econf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wa, input logic [2:0] ra, input logic [7:0] da,
                         input logic wb, input logic [2:0] rb, input logic [7:0] db,
                         input logic c);
        WENA = wa; RWA = ra; busWA = da;
        WENB = wb; RWB = rb; busWB = db;
        clr = c;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
    endtask

    // one write per port in the cycle, then the edge; inputs change on negedge
    task automatic wr2(input logic [2:0] ra, input logic [7:0] da,
                       input logic [2:0] rb, input logic [7:0] db);
        @(negedge Clk);
        drive(1'b1, ra, da, 1'b1, rb, db, 1'b0);
    endtask

    initial begin
        //          wena rwa bwa  wenb rwb bwb  rx ry rz  ex   ey   ez   conf
        vecs[0]  = '{0, 0, 0,    0, 0, 0,    0, 1, 7,  0,   0,   0,   0};
        vecs[1]  = '{0, 0, 0,    0, 0, 0,    2, 3, 4,  0,   0,   0,   0};
        vecs[2]  = '{0, 0, 0,    0, 0, 0,    5, 6, 7,  0,   0,   0,   0};
        vecs[3]  = '{1, 0, 55,   1, 1, 100,  0, 1, 2,  0,   100, 0,   0};
        vecs[4]  = '{0, 0, 0,    0, 0, 0,    0, 1, 0,  0,   100, 0,   0};
        vecs[5]  = '{1, 7, 32,   1, 7, 255,  7, 7, 1,  255, 255, 100, 0};
        vecs[6]  = '{1, 2, 50,   1, 5, 26,   7, 0, 2,  255, 0,   50,  1};
        vecs[7]  = '{0, 0, 0,    0, 0, 0,    2, 5, 7,  50,  26,  255, 0};
        vecs[8]  = '{0, 6, 105,  0, 3, 77,   6, 3, 1,  0,   0,   100, 0};
        vecs[9]  = '{0, 0, 0,    0, 0, 0,    6, 1, 7,  0,   100, 255, 0};
        vecs[10] = '{1, 0, 11,   1, 0, 22,   0, 0, 5,  0,   0,   26,  0};
        vecs[11] = '{0, 0, 0,    0, 0, 0,    0, 2, 5,  0,   50,  26,  1};
        vecs[12] = '{0, 0, 0,    0, 0, 0,    7, 5, 2,  255, 26,  50,  0};

        idle_inputs();
        RX = 0; RY = 0; RZ = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        chk("reset_ready", {7'd0, ready}, 8'd1);
        chk("reset_conflict", {7'd0, conflict}, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge Clk);
            drive(vecs[i].wena, vecs[i].rwa, vecs[i].bwa,
                  vecs[i].wenb, vecs[i].rwb, vecs[i].bwb, 1'b0);
            RX = vecs[i].rx; RY = vecs[i].ry; RZ = vecs[i].rz;
            #1;
            chk($sformatf("vec%0d_busX", i), busX, vecs[i].ex);
            chk($sformatf("vec%0d_busY", i), busY, vecs[i].ey);
            chk($sformatf("vec%0d_busZ", i), busZ, vecs[i].ez);
            chk($sformatf("vec%0d_conflict", i), {7'd0, conflict}, {7'd0, vecs[i].econf});
            chk($sformatf("vec%0d_ready", i), {7'd0, ready}, 8'd1);
        end

        // Bulk clear: fill r1..r7 = 1..7, then clr with a competing write to r3
        wr2(3'd1, 8'd1, 3'd2, 8'd2);
        wr2(3'd3, 8'd3, 3'd4, 8'd4);
        wr2(3'd5, 8'd5, 3'd6, 8'd6);
        wr2(3'd7, 8'd7, 3'd0, 8'd0);
        @(negedge Clk);
        drive(1'b1, 3'd3, 8'd99, 1'b0, 3'd0, 8'd0, 1'b1);
        RX = 3'd3; RY = 3'd1; RZ = 3'd7;
        #1;
        chk("clr_edge_no_bypass_r3", busX, 8'd3);
        chk("clr_edge_ready", {7'd0, ready}, 8'd1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            drive(1'b1, 3'd7, 8'hEE, 1'b1, 3'd6, 8'hDD, c[0]);
            #1;
            chk($sformatf("clear%0d_ready", c), {7'd0, ready}, 8'd0);
            chk($sformatf("clear%0d_r3", c), busX, (c <= 4) ? 8'd3 : 8'd0);
            chk($sformatf("clear%0d_r1", c), busY, (c <= 2) ? 8'd1 : 8'd0);
            chk($sformatf("clear%0d_r7", c), busZ, 8'd7);
            chk($sformatf("clear%0d_conflict", c), {7'd0, conflict}, 8'd0);
        end
        @(negedge Clk);
        idle_inputs();
        RX = 3'd3; RY = 3'd6; RZ = 3'd7;
        #1;
        chk("clear_done_ready", {7'd0, ready}, 8'd1);
        chk("clear_done_r3", busX, 8'd0);
        chk("clear_done_r6", busY, 8'd0);
        chk("clear_done_r7", busZ, 8'd0);
        chk("clear_done_conflict", {7'd0, conflict}, 8'd0);
        wr2(3'd2, 8'd42, 3'd6, 8'd61);
        @(negedge Clk);
        idle_inputs();
        RX = 3'd2; RY = 3'd6;
        #1;
        chk("post_clear_write_a", busX, 8'd42);
        chk("post_clear_write_b", busY, 8'd61);
        chk("post_clear_still_ready", {7'd0, ready}, 8'd1);

        // Reset in the middle of a clear
        wr2(3'd5, 8'd5, 3'd7, 8'd77);
        @(negedge Clk);
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b1);
        repeat (3) begin
            @(negedge Clk);
            idle_inputs();
        end
        RX = 3'd5; RY = 3'd7; RZ = 3'd2;
        #1;
        chk("pre_reset_clearing", {7'd0, ready}, 8'd0);
        chk("pre_reset_r5", busX, 8'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_clear_reset_ready", {7'd0, ready}, 8'd1);
        chk("mid_clear_reset_r5", busX, 8'd0);
        chk("mid_clear_reset_r7", busY, 8'd0);
        for (int a = 0; a < 8; a++) begin
            RZ = 3'(a);
            #1;
            chk($sformatf("mid_clear_reset_r%0d", a), busZ, 8'd0);
        end
        @(negedge Clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd4, 8'd207, 1'b0, 3'd0, 8'd0, 1'b0);
        RX = 3'd4;
        #1;
        chk("after_reset_bypass_r4", busX, 8'd207);
        @(negedge Clk);
        idle_inputs();
        #1;
        chk("after_reset_r4", busX, 8'd207);
        repeat (10) @(negedge Clk);
        #1;
        chk("no_clear_resume_ready", {7'd0, ready}, 8'd1);
        chk("no_clear_resume_r4", busX, 8'd207);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
